// File: rtl/ssd_pkg.sv
// Shared symbol codes and scheduler state for the seven-segment display path.
// The lock FSM imports this package so the two sides use the same codes.
package ssd_pkg;

    typedef enum logic {MAIN, ALERT} state_e;

    localparam logic [4:0] SYM_0 = 5'h00, SYM_1 = 5'h01, SYM_2 = 5'h02, SYM_3 = 5'h03;
    localparam logic [4:0] SYM_4 = 5'h04, SYM_5 = 5'h05, SYM_6 = 5'h06, SYM_7 = 5'h07;
    localparam logic [4:0] SYM_8 = 5'h08, SYM_9 = 5'h09, SYM_A = 5'h0A, SYM_B = 5'h0B;
    localparam logic [4:0] SYM_C = 5'h0C, SYM_D = 5'h0D, SYM_E = 5'h0E, SYM_F = 5'h0F;
    // Letters that share a glyph with a hex digit reuse its code.
    localparam logic [4:0] SYM_S     = 5'h05;
    localparam logic [4:0] SYM_O     = 5'h00;
    localparam logic [4:0] SYM_L     = 5'h10;
    localparam logic [4:0] SYM_P     = 5'h11;
    localparam logic [4:0] SYM_TIRE  = 5'h12;
    localparam logic [4:0] SYM_BLANK = 5'h13;

    // Digit idx of a 4-symbol message; idx 0 is the rightmost digit.
    function automatic logic [4:0] sym_at(input logic [19:0] code, input logic [1:0] idx);
        sym_at = code[4:0];
        case (idx)
            2'd0: sym_at = code[4:0];
            2'd1: sym_at = code[9:5];
            2'd2: sym_at = code[14:10];
            2'd3: sym_at = code[19:15];
            default: sym_at = code[4:0];
        endcase
    endfunction

endpackage

// File: rtl/binary_to_segment.sv
// Combinational 5-bit symbol code to active-low {g..a} segment decoder.
// Codes outside the defined set light nothing.
module binary_to_segment
    import ssd_pkg::*;
(
    input  logic [4:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h7F;
        case (i_code)
            SYM_0:    o_seg = 7'h40;
            SYM_1:    o_seg = 7'h79;
            SYM_2:    o_seg = 7'h24;
            SYM_3:    o_seg = 7'h30;
            SYM_4:    o_seg = 7'h19;
            SYM_5:    o_seg = 7'h12;
            SYM_6:    o_seg = 7'h02;
            SYM_7:    o_seg = 7'h78;
            SYM_8:    o_seg = 7'h00;
            SYM_9:    o_seg = 7'h10;
            SYM_A:    o_seg = 7'h08;
            SYM_B:    o_seg = 7'h03;
            SYM_C:    o_seg = 7'h46;
            SYM_D:    o_seg = 7'h21;
            SYM_E:    o_seg = 7'h06;
            SYM_F:    o_seg = 7'h0E;
            SYM_L:    o_seg = 7'h47;
            SYM_P:    o_seg = 7'h0C;
            SYM_TIRE: o_seg = 7'h3F;
            default:  o_seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/ssd_display_scheduler.sv
// Scans the 4-digit display, blinks prompt digits and lets one-shot alerts
// pre-empt the main message for a fixed hold time.
module ssd_display_scheduler
    import ssd_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLINK_DIV   = 50000000,
    parameter int unsigned ALERT_HOLD  = 200000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_display_en,
    input  logic [19:0] i_main_code,
    input  logic [3:0]  i_main_blink,
    input  logic        i_alert_valid,
    input  logic [19:0] i_alert_code,
    output logic        o_alert_ready,
    output logic        o_alert_active,
    output logic [3:0]  o_an,
    output logic [6:0]  o_seg
);

    localparam int unsigned RefW   = $clog2(REFRESH_DIV + 1);
    localparam int unsigned BlinkW = $clog2(BLINK_DIV + 1);
    localparam int unsigned HoldW  = $clog2(ALERT_HOLD + 1);

    localparam logic [RefW-1:0]   RefLast   = RefW'(REFRESH_DIV - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);
    localparam logic [HoldW-1:0]  HoldLoad  = HoldW'(ALERT_HOLD - 1);

    state_e              r_state;
    state_e              w_state_next;
    logic                r_rst_done;
    logic [HoldW-1:0]    r_hold_cnt;
    logic [19:0]         r_alert_code;
    logic [RefW-1:0]     r_ref_cnt;
    logic [1:0]          r_idx;
    logic [BlinkW-1:0]   r_blink_cnt;
    logic                r_phase;
    logic                r_blink_any;
    logic [3:0]          r_an;
    logic [6:0]          r_seg;
    logic                w_accept;
    logic                w_blink_rise;
    logic                w_phase_on;
    logic [4:0]          w_sym;
    logic [6:0]          w_seg;

    assign o_alert_ready  = r_rst_done && (r_state == MAIN);
    assign o_alert_active = (r_state == ALERT);
    assign o_an           = r_an;
    assign o_seg          = r_seg;

    assign w_accept     = o_alert_ready && i_alert_valid;
    assign w_blink_rise = !r_blink_any && (i_main_blink != 4'b0000);
    // A fresh prompt is shown on the very edge the mask rises.
    assign w_phase_on   = r_phase || w_blink_rise;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MAIN:    if (w_accept) w_state_next = ALERT;
            ALERT:   if (r_hold_cnt == '0) w_state_next = MAIN;
            default: w_state_next = MAIN;
        endcase
    end

    always_comb begin
        w_sym = SYM_BLANK;
        if (r_state == ALERT) begin
            w_sym = sym_at(r_alert_code, r_idx);
        end else if (i_main_blink[r_idx] && !w_phase_on) begin
            w_sym = SYM_BLANK;
        end else begin
            w_sym = sym_at(i_main_code, r_idx);
        end
    end

    binary_to_segment u_decode (
        .i_code (w_sym),
        .o_seg  (w_seg)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= MAIN;
            r_rst_done   <= 1'b0;
            r_hold_cnt   <= '0;
            r_alert_code <= '0;
            r_ref_cnt    <= '0;
            r_idx        <= 2'd0;
            r_blink_cnt  <= '0;
            r_phase      <= 1'b1;
            r_blink_any  <= 1'b0;
            r_an         <= 4'b1111;
            r_seg        <= 7'h7F;
        end else begin
            r_state     <= w_state_next;
            r_rst_done  <= 1'b1;
            r_blink_any <= (i_main_blink != 4'b0000);

            if (w_accept) begin
                r_hold_cnt   <= HoldLoad;
                r_alert_code <= i_alert_code;
            end else if ((r_state == ALERT) && (r_hold_cnt != '0)) begin
                r_hold_cnt <= r_hold_cnt - HoldW'(1);
            end

            if (r_ref_cnt == RefLast) begin
                r_ref_cnt <= '0;
                r_idx     <= r_idx + 2'd1;
            end else begin
                r_ref_cnt <= r_ref_cnt + RefW'(1);
            end

            if (w_blink_rise) begin
                r_blink_cnt <= '0;
                r_phase     <= 1'b1;
            end else if (r_blink_cnt == BlinkLast) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BlinkW'(1);
            end

            r_an  <= i_display_en ? ~(4'b0001 << r_idx) : 4'b1111;
            r_seg <= w_seg;
        end
    end

endmodule

// File: tb/tb_ssd_display_scheduler.sv
// Directed-plus-random bench for ssd_display_scheduler against a cycle-count
// reference model derived from elapsed time since reset and blink restart.
module tb_ssd_display_scheduler;

    localparam int REF  = 4;
    localparam int BL   = 16;
    localparam int HOLD = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        display_en = 1'b1;
    logic [19:0] main_code = '0;
    logic [3:0]  main_blink = '0;
    logic        alert_valid = 1'b0;
    logic [19:0] alert_code = '0;
    logic        alert_ready;
    logic        alert_active;
    logic [3:0]  an;
    logic [6:0]  seg;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit          m_done;
    int          m_left;
    int          m_n;
    int          m_bs;
    bit          m_bprev;
    logic [19:0] m_acode;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;

    always #5 clk = ~clk;

    ssd_display_scheduler #(
        .REFRESH_DIV (REF),
        .BLINK_DIV   (BL),
        .ALERT_HOLD  (HOLD)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_display_en   (display_en),
        .i_main_code    (main_code),
        .i_main_blink   (main_blink),
        .i_alert_valid  (alert_valid),
        .i_alert_code   (alert_code),
        .o_alert_ready  (alert_ready),
        .o_alert_active (alert_active),
        .o_an           (an),
        .o_seg          (seg)
    );

    // Glyph table written active-high {g..a}, inverted for the active-low pins.
    function automatic logic [6:0] glyph(input logic [4:0] s);
        logic [6:0] hi;
        case (s)
            5'h00: hi = 7'h3F;  5'h01: hi = 7'h06;  5'h02: hi = 7'h5B;  5'h03: hi = 7'h4F;
            5'h04: hi = 7'h66;  5'h05: hi = 7'h6D;  5'h06: hi = 7'h7D;  5'h07: hi = 7'h07;
            5'h08: hi = 7'h7F;  5'h09: hi = 7'h6F;  5'h0A: hi = 7'h77;  5'h0B: hi = 7'h7C;
            5'h0C: hi = 7'h39;  5'h0D: hi = 7'h5E;  5'h0E: hi = 7'h79;  5'h0F: hi = 7'h71;
            5'h10: hi = 7'h38;  5'h11: hi = 7'h73;  5'h12: hi = 7'h40;
            default: hi = 7'h00;
        endcase
        return ~hi;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict from pre-edge model state and inputs, then compare.
    task automatic tick();
        int         idx;
        bit         rise;
        bit         ph;
        bit         rdy;
        logic [4:0] sym;
        if (!rst) begin
            e_an = 4'b1111;  e_seg = 7'h7F;
            m_done = 0;  m_left = 0;  m_n = 0;  m_bs = 0;  m_bprev = 0;
        end else begin
            idx  = (m_n / REF) % 4;
            rise = !m_bprev && (main_blink != 4'b0000);
            ph   = rise || ((((m_n - m_bs) / BL) % 2) == 0);
            if (m_left > 0)                     sym = 5'(m_acode >> (5 * idx));
            else if (main_blink[idx] && !ph)    sym = 5'h13;
            else                                sym = 5'(main_code >> (5 * idx));
            e_an  = display_en ? ~(4'(1) << idx) : 4'b1111;
            e_seg = glyph(sym);
            rdy = m_done && (m_left == 0);
            if (m_left > 0) m_left--;
            else if (rdy && alert_valid) begin
                m_left  = HOLD;
                m_acode = alert_code;
            end
            if (rise) m_bs = m_n + 1;
            m_n++;
            m_bprev = (main_blink != 4'b0000);
            m_done  = 1;
        end
        @(posedge clk);
        #1;
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("alert_ready", 32'(alert_ready), 32'(m_done && (m_left == 0)));
        chk("alert_active", 32'(alert_active), 32'(m_left > 0));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int act_cnt;
    int nrdy_cnt;

    initial begin
        // Reset
        rst = 1'b0;
        ticks(3);
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_seg", 32'(seg), 32'h7F);

        // Scan after release, {C,b,C,d}
        main_code = {5'h0C, 5'h0B, 5'h0C, 5'h0D};
        rst = 1'b1;
        tick();
        chk("ready_first_cycle", 32'(alert_ready), 32'd1);
        chk("first_digit_an", 32'(an), 32'hE);
        ticks(19);

        // Blink on leftmost digit showing 5
        main_code  = {5'h05, 15'($urandom)};
        main_blink = 4'b1000;
        ticks(45);
        main_blink = 4'b0000;
        ticks(3);
        main_blink = 4'b1000;
        ticks(40);
        main_blink = 4'b0000;

        // Live sampling of main_code
        for (int i = 0; i < 12; i++) begin
            main_code = 20'($urandom);
            tick();
        end

        // Single alert {E,C,3,blank}
        alert_valid = 1'b1;
        alert_code  = {5'h0E, 5'h0C, 5'h03, 5'h13};
        tick();
        alert_valid = 1'b0;
        act_cnt  = alert_active ? 1 : 0;
        nrdy_cnt = alert_ready ? 0 : 1;
        for (int i = 0; i < 25; i++) begin
            alert_code = 20'($urandom);
            tick();
            if (alert_active) act_cnt++;
            if (!alert_ready) nrdy_cnt++;
        end
        chk("alert_active_len", 32'(act_cnt), 32'(HOLD));
        chk("alert_notready_len", 32'(nrdy_cnt), 32'(HOLD));

        // Back-to-back alerts
        alert_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            alert_code = 20'($urandom);
            tick();
        end
        alert_valid = 1'b0;
        ticks(25);

        // Reset mid-alert
        alert_valid = 1'b1;
        alert_code  = 20'($urandom);
        tick();
        alert_valid = 1'b0;
        ticks(7);
        rst = 1'b0;
        tick();
        chk("rst_mid_alert_active", 32'(alert_active), 32'd0);
        chk("rst_mid_alert_an", 32'(an), 32'hF);
        rst = 1'b1;
        main_code = 20'($urandom);
        ticks(16);

        // Display enable gap
        display_en = 1'b0;
        ticks(10);
        display_en = 1'b1;
        ticks(10);

        // Random soak
        for (int i = 0; i < 300; i++) begin
            main_code   = 20'($urandom);
            main_blink  = ($urandom_range(0, 9) < 2) ? 4'($urandom) : main_blink;
            display_en  = ($urandom_range(0, 9) != 0);
            alert_valid = ($urandom_range(0, 29) == 0) ? 1'b1 : (alert_valid && !alert_ready);
            alert_code  = 20'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
